pkt_rate_limiter: RTL and testbench

Packet-boundary-aware token-bucket rate limiter. It sits directly downstream of the IDS stage in the user data path and consumes that stage's `out_data`/`out_ctrl`/`out_wr`/`out_rdy` stream. It forwards whole packets towards the output queues, and admits a new packet only when the bucket holds credit. The bucket is charged one token per forwarded word, so long-term word rate is bounded by the configured refill interval.

---
 rtl/pkt_rate_limiter_if.sv | 13 +
 rtl/pkt_rate_limiter.sv | 202 ++++++++++++++++++++
 tb/tb_pkt_rate_limiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_rate_limiter_if.sv
// Word stream: data/ctrl words qualified by a write strobe, with ready backpressure.
interface pkt_rate_limiter_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input rdy);
    modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/pkt_rate_limiter.sv
// Packet-boundary-aware token-bucket rate limiter behind a 4-deep fall-through input FIFO.
// Define PKT_RATE_LIMITER_STATS_EN to build the packet/word/drop statistics counters.
module pkt_rate_limiter #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned TOKEN_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    pkt_rate_limiter_if.slave             in_bus,
    pkt_rate_limiter_if.master            out_bus,
    input  logic                          cfg_enable,
    input  logic [15:0]                   cfg_interval,
    input  logic [TOKEN_WIDTH-1:0]        cfg_burst,
    output logic signed [TOKEN_WIDTH-1:0] tokens,
    output logic [31:0]                   stat_pkts,
    output logic [31:0]                   stat_words,
    output logic [31:0]                   stat_drop_words
);

    localparam int unsigned Depth = 4;
    localparam int unsigned FifoW = CTRL_WIDTH + DATA_WIDTH;
    localparam int unsigned TokW1 = TOKEN_WIDTH + 1;
    localparam logic signed [TokW1-1:0] TokFloor = {2'b11, {(TOKEN_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

    // ---------------- input FIFO ----------------
    logic [FifoW-1:0] mem_q [Depth];
    logic [1:0]       wr_ptr_q, rd_ptr_q;
    logic [2:0]       count_q;
    logic             fifo_empty, nearly_full, push, pop;
    logic [FifoW-1:0] head;
    logic [CTRL_WIDTH-1:0] head_ctrl;

    assign push        = in_bus.wr;
    assign fifo_empty  = (count_q == 3'd0);
    assign nearly_full = (count_q >= 3'(Depth - 1));
    assign in_bus.rdy  = !nearly_full;

    assign head          = mem_q[rd_ptr_q];
    assign head_ctrl     = head[FifoW-1:DATA_WIDTH];
    assign out_bus.data  = head[DATA_WIDTH-1:0];
    assign out_bus.ctrl  = head_ctrl;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_bus.ctrl, in_bus.data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + 3'(push) - 3'(pop);
        end
    end

    // ---------------- packet FSM ----------------
    state_e state_q, state_d;
    logic   admit, fwd, drop;
    logic signed [TOKEN_WIDTH-1:0] tokens_q, tokens_d;

    // Admission looks at the bucket only at a packet head; in-flight packets ignore it.
    assign admit = !cfg_enable || (!tokens_q[TOKEN_WIDTH-1] && (tokens_q != '0));

    always_comb begin
        state_d = state_q;
        fwd     = 1'b0;
        drop    = 1'b0;
        if (!fifo_empty && out_bus.rdy) begin
            unique case (state_q)
                StIdle: begin
                    if (head_ctrl != '0) begin
                        if (admit) begin
                            fwd     = 1'b1;
                            state_d = StHdr;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
                StHdr: begin
                    fwd = 1'b1;
                    if (head_ctrl == '0) begin
                        state_d = StBody;
                    end
                end
                StBody: begin
                    fwd = 1'b1;
                    if (head_ctrl != '0) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign pop         = fwd || drop;
    assign out_bus.wr  = fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- refill interval ----------------
    logic [15:0] ivl_q, ivl_last;
    logic        refill;

    assign ivl_last = (cfg_interval == 16'd0) ? 16'd0 : cfg_interval - 16'd1;
    // >= so that shrinking cfg_interval below the running count wraps immediately.
    assign refill   = (ivl_q >= ivl_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            ivl_q <= 16'd0;
        end else if (refill) begin
            ivl_q <= 16'd0;
        end else begin
            ivl_q <= ivl_q + 16'd1;
        end
    end

    // ---------------- token bucket ----------------
    logic signed [TokW1-1:0] tok_sum, tok_cap;

    assign tok_sum = {tokens_q[TOKEN_WIDTH-1], tokens_q} + TokW1'(refill) - TokW1'(fwd);
    assign tok_cap = {1'b0, cfg_burst};

    always_comb begin
        tokens_d = tok_sum[TOKEN_WIDTH-1:0];
        if (!cfg_enable) begin
            tokens_d = cfg_burst;
        end else if (tok_sum > tok_cap) begin
            tokens_d = cfg_burst;
        end else if (tok_sum < TokFloor) begin
            tokens_d = {1'b1, {(TOKEN_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tokens_q <= cfg_burst;
        end else begin
            tokens_q <= tokens_d;
        end
    end

    assign tokens = tokens_q;

    // ---------------- statistics ----------------
`ifdef PKT_RATE_LIMITER_STATS_EN
    logic [31:0] pkts_q, words_q, drops_q;
    logic        pkt_done;

    assign pkt_done = fwd && (state_q == StBody) && (head_ctrl != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pkts_q  <= 32'd0;
            words_q <= 32'd0;
            drops_q <= 32'd0;
        end else begin
            if (pkt_done) begin
                pkts_q <= pkts_q + 32'd1;
            end
            if (fwd) begin
                words_q <= words_q + 32'd1;
            end
            if (drop) begin
                drops_q <= drops_q + 32'd1;
            end
        end
    end

    assign stat_pkts       = pkts_q;
    assign stat_words      = words_q;
    assign stat_drop_words = drops_q;
`else
    assign stat_pkts       = 32'd0;
    assign stat_words      = 32'd0;
    assign stat_drop_words = 32'd0;
`endif

    // Upstream must honour in_rdy; a write into a full FIFO corrupts it.
    assert property (@(posedge clk) disable iff (reset) !(in_bus.wr && count_q == 3'(Depth)));

endmodule

// File: tb/tb_pkt_rate_limiter.sv
// Randomised bench for pkt_rate_limiter against a cycle-level queue/arithmetic reference model.
module tb_pkt_rate_limiter;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int TW = 16;

    typedef logic [CW+DW-1:0] word_t;

    logic clk = 1'b0;
    logic reset;
    logic cfg_enable;
    logic [15:0] cfg_interval;
    logic [TW-1:0] cfg_burst;
    logic signed [TW-1:0] tokens;
    logic [31:0] stat_pkts, stat_words, stat_drop_words;

    always #5 clk = ~clk;

    pkt_rate_limiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in_bus ();
    pkt_rate_limiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_bus ();

    pkt_rate_limiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .TOKEN_WIDTH(TW)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_bus          (in_bus),
        .out_bus         (out_bus),
        .cfg_enable      (cfg_enable),
        .cfg_interval    (cfg_interval),
        .cfg_burst       (cfg_burst),
        .tokens          (tokens),
        .stat_pkts       (stat_pkts),
        .stat_words      (stat_words),
        .stat_drop_words (stat_drop_words)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    word_t src_q[$], m_fifo[$], got_q[$], exp_q[$], last_pkt[$];
    int    m_tok, m_cnt, m_pkts, m_words, m_drops;
    bit    m_in_pkt, m_body;
    int    cyc = 0;
    int    wr_cyc_q[$];
    int    wr_bad, tok_bad, rdy_bad, tok_lo, tok_hi;
    bit    rdy_low_seen, rst_now;
    int    rdy_mode;
    string first_bad;

    task automatic clear_log();
        got_q.delete(); exp_q.delete(); wr_cyc_q.delete();
        wr_bad = 0; tok_bad = 0; rdy_bad = 0;
        tok_lo = 1 << 20; tok_hi = -(1 << 20);
        rdy_low_seen = 0; first_bad = "";
    endtask

    function automatic int sb_errors();
        int e = 0;
        if (got_q.size() != exp_q.size()) e++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) e++;
        return e;
    endfunction

    task automatic push_pkt(int len);
        word_t w;
        last_pkt.delete();
        for (int i = 0; i < len; i++) begin
            w[DW-1:0] = {$urandom, $urandom};
            w[CW+DW-1 -: CW] = (i == 0) ? 8'hFF : (i == len - 1) ? 8'h80 : 8'h00;
            src_q.push_back(w);
            last_pkt.push_back(w);
        end
    endtask

    // One clock: drive inputs, compare against model, advance model at the edge.
    task automatic step();
        word_t head;
        bit    exp_wr, drop, refill, adm;
        int    eff, t, burst, tk;
        logic [TW-1:0] exp_tok;
        @(negedge clk);
        reset = rst_now;
        case (rdy_mode)
            0:       out_bus.rdy = 1'b1;
            1:       out_bus.rdy = ~out_bus.rdy;
            default: out_bus.rdy = 1'($urandom_range(0, 1));
        endcase
        in_bus.wr = 1'b0;
        if (!rst_now && src_q.size() > 0 && m_fifo.size() < 3) begin
            in_bus.wr = 1'b1;
            {in_bus.ctrl, in_bus.data} = src_q[0];
        end
        #1;
        head = '0; exp_wr = 0; drop = 0;
        adm = !cfg_enable || (m_tok > 0);
        if (m_fifo.size() > 0 && out_bus.rdy) begin
            head = m_fifo[0];
            if (m_in_pkt) exp_wr = 1;
            else if (head[CW+DW-1 -: CW] != 0) exp_wr = adm;
            else drop = 1;
        end
        if (out_bus.wr !== exp_wr) begin
            wr_bad++;
            if (first_bad == "") first_bad = $sformatf("cyc %0d out_wr=%b want %b", cyc, out_bus.wr, exp_wr);
        end
        exp_tok = m_tok[TW-1:0];
        if (tokens !== exp_tok) begin
            tok_bad++;
            if (first_bad == "") first_bad = $sformatf("cyc %0d tokens=%0d want %0d", cyc, tokens, m_tok);
        end
        if (in_bus.rdy !== (m_fifo.size() < 3)) begin
            rdy_bad++;
            if (first_bad == "") first_bad = $sformatf("cyc %0d in_rdy=%b fifo=%0d", cyc, in_bus.rdy, m_fifo.size());
        end
        if (in_bus.rdy === 1'b0) rdy_low_seen = 1;
        tk = tokens;
        if (tk < tok_lo) tok_lo = tk;
        if (tk > tok_hi) tok_hi = tk;
        if (out_bus.wr === 1'b1) begin
            got_q.push_back({out_bus.ctrl, out_bus.data});
            wr_cyc_q.push_back(cyc);
        end
        if (exp_wr) exp_q.push_back(head);
        @(posedge clk);
        cyc++;
        if (rst_now) begin
            m_fifo.delete(); m_in_pkt = 0; m_body = 0; m_tok = int'(cfg_burst);
            m_cnt = 0; m_pkts = 0; m_words = 0; m_drops = 0;
        end else begin
            eff = (cfg_interval == 16'd0) ? 1 : int'(cfg_interval);
            refill = (m_cnt >= eff - 1);
            if (exp_wr || drop) void'(m_fifo.pop_front());
            if (drop) m_drops++;
            if (exp_wr) begin
                m_words++;
                if (!m_in_pkt) begin m_in_pkt = 1; m_body = 0; end
                else if (head[CW+DW-1 -: CW] == 0) m_body = 1;
                else if (m_body) begin m_in_pkt = 0; m_pkts++; end
            end
            burst = int'(cfg_burst);
            if (!cfg_enable) m_tok = burst;
            else begin
                t = m_tok + (refill ? 1 : 0) - (exp_wr ? 1 : 0);
                if (t > burst) t = burst;
                if (t < -(1 << (TW - 1))) t = -(1 << (TW - 1));
                m_tok = t;
            end
            m_cnt = refill ? 0 : m_cnt + 1;
            if (in_bus.wr) m_fifo.push_back(src_q.pop_front());
        end
    endtask

    task automatic do_reset();
        src_q.delete();
        rst_now = 1;
        step();
        rst_now = 0;
        clear_log();
    endtask

    task automatic drain(int bound, output bit timed_out);
        int n = 0;
        while ((src_q.size() > 0 || m_fifo.size() > 0) && n < bound) begin
            step();
            n++;
        end
        step(); step();
        timed_out = (n >= bound);
    endtask

    task automatic test_reset();
        cfg_enable = 1; cfg_burst = 16'd5; cfg_interval = 16'd3; rdy_mode = 0;
        rst_now = 1; step(); step(); rst_now = 0;
        clear_log();
        #1;
        n_tests++; if (in_bus.rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got %b want 1", in_bus.rdy); end
        n_tests++; if (out_bus.wr !== 1'b0) begin n_fail++; $display("FAIL reset_out_wr got %b want 0", out_bus.wr); end
        n_tests++; if (tokens !== 16'sd5) begin n_fail++; $display("FAIL reset_tokens got %0d want 5", tokens); end
        n_tests++;
        if ({stat_pkts, stat_words, stat_drop_words} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", stat_pkts, stat_words, stat_drop_words);
        end
    endtask

    task automatic test_passthrough();
        bit to;
        cfg_enable = 0; cfg_burst = 16'd7; cfg_interval = 16'd4; rdy_mode = 0;
        do_reset();
        push_pkt(5);
        drain(50, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL pass_timeout got timeout want drained"); end
        n_tests++; if (wr_bad + tok_bad + rdy_bad != 0) begin n_fail++; $display("FAIL pass_model got %0d bad cycles (%s) want 0", wr_bad + tok_bad + rdy_bad, first_bad); end
        n_tests++; if (sb_errors() != 0) begin n_fail++; $display("FAIL pass_words got %0d errors want 0", sb_errors()); end
        n_tests++;
        if (wr_cyc_q.size() != 5 || wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0] != 4) begin
            n_fail++; $display("FAIL pass_consecutive got %0d pulses want 5 back-to-back", wr_cyc_q.size());
        end
        n_tests++;
        if (got_q.size() != 5 || got_q[0] !== last_pkt[0] || got_q[4] !== last_pkt[4]) begin
            n_fail++; $display("FAIL pass_data got %0d words want sent packet unchanged", got_q.size());
        end
`ifdef PKT_RATE_LIMITER_STATS_EN
        n_tests++; if (stat_pkts !== 32'd1 || stat_words !== 32'd5) begin n_fail++; $display("FAIL pass_stats got %0d/%0d want 1/5", stat_pkts, stat_words); end
`endif
    endtask

    task automatic test_limit();
        bit to;
        int c0, gap, stalls;
        cfg_enable = 1; cfg_burst = 16'd2; cfg_interval = 16'd10; rdy_mode = 0;
        do_reset();
        c0 = cyc;
        for (int p = 0; p < 3; p++) push_pkt(5);
        drain(400, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL limit_timeout got timeout want drained"); end
        n_tests++; if (wr_bad + tok_bad + rdy_bad != 0) begin n_fail++; $display("FAIL limit_model got %0d bad cycles (%s) want 0", wr_bad + tok_bad + rdy_bad, first_bad); end
        n_tests++; if (sb_errors() != 0) begin n_fail++; $display("FAIL limit_words got %0d errors want 0", sb_errors()); end
        n_tests++; if (wr_cyc_q.size() == 0 || wr_cyc_q[0] != c0 + 1) begin n_fail++; $display("FAIL limit_first_start got %0d pulses want first at cycle %0d", wr_cyc_q.size(), c0 + 1); end
        gap = (wr_cyc_q.size() >= 6) ? wr_cyc_q[5] - wr_cyc_q[4] : -1;
        n_tests++; if (gap < 30 || gap > 45) begin n_fail++; $display("FAIL limit_hold got gap %0d want 30..45", gap); end
        stalls = (wr_cyc_q.size() == 15) ? 0 : 1;
        for (int k = 0; k < 3 && wr_cyc_q.size() == 15; k++)
            if (wr_cyc_q[5*k+4] - wr_cyc_q[5*k] != 4) stalls++;
        n_tests++; if (stalls != 0) begin n_fail++; $display("FAIL limit_no_stall got %0d stalled packets want 0", stalls); end
    endtask

    task automatic test_rdy_toggle();
        bit to;
        cfg_enable = 0; cfg_burst = 16'd4; cfg_interval = 16'd2; rdy_mode = 1;
        do_reset();
        push_pkt(8);
        drain(100, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL toggle_timeout got timeout want drained"); end
        n_tests++; if (wr_bad + tok_bad + rdy_bad != 0) begin n_fail++; $display("FAIL toggle_model got %0d bad cycles (%s) want 0", wr_bad + tok_bad + rdy_bad, first_bad); end
        n_tests++; if (sb_errors() != 0 || got_q.size() != 8) begin n_fail++; $display("FAIL toggle_words got %0d words want 8 intact", got_q.size()); end
        n_tests++; if (!rdy_low_seen) begin n_fail++; $display("FAIL toggle_in_rdy got in_rdy never low want low when nearly full"); end
    endtask

    task automatic test_malformed();
        bit to;
        word_t bad;
        cfg_enable = 0; cfg_burst = 16'd4; cfg_interval = 16'd2; rdy_mode = 0;
        do_reset();
        bad = {8'h00, 32'hDEAD_BEEF, $urandom};
        src_q.push_back(bad);
        push_pkt(4);
        drain(50, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL malformed_timeout got timeout want drained"); end
        n_tests++; if (wr_bad + tok_bad + rdy_bad != 0) begin n_fail++; $display("FAIL malformed_model got %0d bad cycles (%s) want 0", wr_bad + tok_bad + rdy_bad, first_bad); end
        n_tests++;
        if (got_q.size() != 4 || got_q[0] !== last_pkt[0] || got_q[3] !== last_pkt[3]) begin
            n_fail++; $display("FAIL malformed_next_pkt got %0d words want 4 from next packet", got_q.size());
        end
`ifdef PKT_RATE_LIMITER_STATS_EN
        n_tests++; if (stat_drop_words !== 32'd1) begin n_fail++; $display("FAIL malformed_drop_stat got %0d want 1", stat_drop_words); end
`else
        n_tests++; if (stat_drop_words !== 32'd0) begin n_fail++; $display("FAIL malformed_drop_stat got %0d want 0", stat_drop_words); end
`endif
    endtask

    task automatic test_interval0();
        bit to;
        cfg_enable = 1; cfg_burst = 16'd1; cfg_interval = 16'd0; rdy_mode = 0;
        do_reset();
        for (int p = 0; p < 6; p++) push_pkt(3);
        drain(200, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL ivl0_timeout got timeout want drained"); end
        n_tests++; if (wr_bad + tok_bad + rdy_bad != 0) begin n_fail++; $display("FAIL ivl0_model got %0d bad cycles (%s) want 0", wr_bad + tok_bad + rdy_bad, first_bad); end
        n_tests++; if (sb_errors() != 0 || got_q.size() != 18) begin n_fail++; $display("FAIL ivl0_words got %0d words want 18", got_q.size()); end
        n_tests++; if (tok_hi > 1 || tok_lo < 0) begin n_fail++; $display("FAIL ivl0_bounds got tokens %0d..%0d want 0..1", tok_lo, tok_hi); end
    endtask

    task automatic test_mid_reset();
        bit to;
        int n = 0;
        cfg_enable = 1; cfg_burst = 16'd3; cfg_interval = 16'd4; rdy_mode = 0;
        do_reset();
        push_pkt(5);
        while (got_q.size() < 2 && n < 20) begin step(); n++; end
        n_tests++; if (got_q.size() < 2) begin n_fail++; $display("FAIL midrst_start got %0d words want 2", got_q.size()); end
        src_q.delete();
        cfg_burst = 16'd6;
        rst_now = 1; step(); rst_now = 0;
        #1;
        n_tests++; if (in_bus.rdy !== 1'b1 || out_bus.wr !== 1'b0) begin n_fail++; $display("FAIL midrst_flush got in_rdy=%b out_wr=%b want 1/0", in_bus.rdy, out_bus.wr); end
        n_tests++; if (tokens !== 16'sd6) begin n_fail++; $display("FAIL midrst_tokens got %0d want 6", tokens); end
        clear_log();
        push_pkt(5);
        drain(60, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL midrst_timeout got timeout want drained"); end
        n_tests++; if (wr_bad + tok_bad + rdy_bad != 0) begin n_fail++; $display("FAIL midrst_model got %0d bad cycles (%s) want 0", wr_bad + tok_bad + rdy_bad, first_bad); end
        n_tests++;
        if (got_q.size() != 5 || got_q[0] !== last_pkt[0] || got_q[4] !== last_pkt[4]) begin
            n_fail++; $display("FAIL midrst_next_pkt got %0d words want 5 from header", got_q.size());
        end
    endtask

    task automatic test_random();
        bit to;
        for (int r = 0; r < 4; r++) begin
            cfg_enable   = ($urandom_range(0, 3) != 0);
            cfg_burst    = 16'($urandom_range(1, 8));
            cfg_interval = 16'($urandom_range(0, 5));
            rdy_mode     = 2;
            do_reset();
            for (int p = 0; p < 20; p++) begin
                if ($urandom_range(0, 3) == 0) src_q.push_back({8'h00, $urandom, $urandom});
                push_pkt($urandom_range(3, 8));
            end
            drain(4000, to);
            n_tests++; if (to) begin n_fail++; $display("FAIL random%0d_timeout got timeout want drained", r); end
            n_tests++; if (wr_bad + tok_bad + rdy_bad != 0) begin n_fail++; $display("FAIL random%0d_model got %0d bad cycles (%s) want 0", r, wr_bad + tok_bad + rdy_bad, first_bad); end
            n_tests++; if (sb_errors() != 0) begin n_fail++; $display("FAIL random%0d_words got %0d errors want 0", r, sb_errors()); end
`ifdef PKT_RATE_LIMITER_STATS_EN
            n_tests++;
            if (stat_pkts !== 32'(m_pkts) || stat_words !== 32'(m_words) || stat_drop_words !== 32'(m_drops)) begin
                n_fail++;
                $display("FAIL random%0d_stats got %0d/%0d/%0d want %0d/%0d/%0d", r, stat_pkts, stat_words, stat_drop_words, m_pkts, m_words, m_drops);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; rst_now = 1'b1; rdy_mode = 0;
        in_bus.wr = 1'b0; in_bus.data = '0; in_bus.ctrl = '0; out_bus.rdy = 1'b1;
        cfg_enable = 1'b1; cfg_interval = 16'd1; cfg_burst = 16'd1;
        m_tok = 0; m_cnt = 0; m_pkts = 0; m_words = 0; m_drops = 0; m_in_pkt = 0; m_body = 0;
        clear_log();
        test_reset();
        test_passthrough();
        test_limit();
        test_rdy_toggle();
        test_malformed();
        test_interval0();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got no completion want finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
